// File: rtl/rename_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rename_pkg
// Description : Shared constants and types for the register rename table.
// Revision    : 1.0 - initial release
// ============================================================================
package rename_pkg;

    localparam int DEF_ARCH_REGS = 32;
    localparam int DEF_PHYS_REGS = 64;

    localparam int AW = $clog2(DEF_ARCH_REGS);
    localparam int PW = $clog2(DEF_PHYS_REGS);

    typedef logic [AW-1:0] areg_t;
    typedef logic [PW-1:0] preg_t;

endpackage
`default_nettype wire

// File: rtl/rename_table_if.sv
`default_nettype none
// ============================================================================
// Module      : rename_table_if
// Description : Decode-side, rename-side and commit-side signals of the
//               rename table. Suffixes are relative to the rename table.
// Revision    : 1.0 - initial release
// ============================================================================
interface rename_table_if
    import rename_pkg::*;
#(
    parameter int ARCH_REGS = DEF_ARCH_REGS,
    parameter int PHYS_REGS = DEF_PHYS_REGS
);
    localparam int ARCH_W = $clog2(ARCH_REGS);
    localparam int PHYS_W = $clog2(PHYS_REGS);

    // decoded instruction in
    logic              in_valid_i;
    logic              in_ready_o;
    logic [6:0]        opcode_i;
    logic [ARCH_W-1:0] rs1_i;
    logic [ARCH_W-1:0] rs2_i;
    logic [ARCH_W-1:0] rd_i;
    logic [31:0]       instr_i;

    // renamed instruction out
    logic              out_valid_o;
    logic              out_ready_i;
    logic [6:0]        opcode_o;
    logic [31:0]       instr_o;
    logic [PHYS_W-1:0] ps1_o;
    logic [PHYS_W-1:0] ps2_o;
    logic [PHYS_W-1:0] pd_o;
    logic [PHYS_W-1:0] old_pd_o;

    // retirement return path and status
    logic              commit_valid_i;
    logic [PHYS_W-1:0] commit_preg_i;
    logic [PHYS_W:0]   free_count_o;
    logic              overflow_err_o;

    modport master (
        output in_valid_i, opcode_i, rs1_i, rs2_i, rd_i, instr_i,
        input  in_ready_o,
        input  out_valid_o, opcode_o, instr_o, ps1_o, ps2_o, pd_o, old_pd_o,
        output out_ready_i,
        output commit_valid_i, commit_preg_i,
        input  free_count_o, overflow_err_o
    );

    modport slave (
        input  in_valid_i, opcode_i, rs1_i, rs2_i, rd_i, instr_i,
        output in_ready_o,
        output out_valid_o, opcode_o, instr_o, ps1_o, ps2_o, pd_o, old_pd_o,
        input  out_ready_i,
        input  commit_valid_i, commit_preg_i,
        output free_count_o, overflow_err_o
    );

endinterface
`default_nettype wire

// File: rtl/rename_free_list.sv
`default_nettype none
// ============================================================================
// Module      : rename_free_list
// Description : Circular FIFO of free physical registers. Pops from head,
//               pushes returned registers at tail, flags sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module rename_free_list
    import rename_pkg::*;
#(
    parameter int ARCH_REGS = DEF_ARCH_REGS,
    parameter int PHYS_REGS = DEF_PHYS_REGS
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         push_i,
    input  wire logic [$clog2(PHYS_REGS)-1:0] push_preg_i,
    input  wire logic                         pop_i,
    output logic      [$clog2(PHYS_REGS)-1:0] head_o,
    output logic      [$clog2(PHYS_REGS):0]   count_o,
    output logic                              overflow_o
);
    localparam int PHYS_W   = $clog2(PHYS_REGS);
    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int PTR_W    = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

    logic [PHYS_W-1:0] fifo_q [FL_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PHYS_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic w_push_valid;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FL_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Register 0 is never a rename target, so returning it is a no-op.
    assign w_push_valid = push_i && (push_preg_i != '0);
    assign w_full       = (count_q == (PHYS_W + 1)'(FL_DEPTH));
    assign w_do_pop     = pop_i && (count_q != '0);
    // A full list still accepts a push when a pop frees a slot this cycle.
    assign w_do_push    = w_push_valid && (!w_full || w_do_pop);

    // Next-state pointers, occupancy and sticky overflow flag.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (w_do_pop) begin
            head_d = next_ptr(head_q);
        end
        if (w_do_push) begin
            tail_d = next_ptr(tail_q);
        end
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            count_d = count_q - 1'b1;
        end
        if (w_push_valid && !w_do_push) begin
            overflow_d = 1'b1;
        end
    end

    // Control state; reset leaves the list full with head == tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= (PHYS_W + 1)'(FL_DEPTH);
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage: reset loads ARCH_REGS..PHYS_REGS-1 in ascending order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fifo_q[i] <= PHYS_W'(ARCH_REGS + i);
            end
        end else if (w_do_push) begin
            fifo_q[tail_q] <= push_preg_i;
        end
    end

    assign head_o     = fifo_q[head_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule
`default_nettype wire

// File: rtl/rename_table.sv
`default_nettype none
// ============================================================================
// Module      : rename_table
// Description : Register alias table with free-list allocation and a single
//               registered output stage (one-cycle rename latency).
// Revision    : 1.0 - initial release
// ============================================================================
module rename_table
    import rename_pkg::*;
#(
    parameter int ARCH_REGS = DEF_ARCH_REGS,
    parameter int PHYS_REGS = DEF_PHYS_REGS
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rename_table_if.slave      bus
);
    localparam int PHYS_W = $clog2(PHYS_REGS);

    logic [PHYS_W-1:0] rat_q [ARCH_REGS];
    logic [PHYS_W-1:0] rat_d [ARCH_REGS];

    logic              out_valid_q, out_valid_d;
    logic [6:0]        opcode_q, opcode_d;
    logic [31:0]       instr_q, instr_d;
    logic [PHYS_W-1:0] ps1_q, ps1_d;
    logic [PHYS_W-1:0] ps2_q, ps2_d;
    logic [PHYS_W-1:0] pd_q, pd_d;
    logic [PHYS_W-1:0] old_pd_q, old_pd_d;

    logic [PHYS_W-1:0] w_fl_head;
    logic [PHYS_W:0]   w_fl_count;
    logic              w_fl_overflow;
    logic              w_rd_zero;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_alloc;

    assign w_rd_zero  = (bus.rd_i == '0);
    // No same-cycle commit bypass: an empty list stalls rd != 0 instructions.
    assign w_in_ready = (!out_valid_q || bus.out_ready_i) &&
                        ((w_fl_count != '0) || w_rd_zero);
    assign w_accept   = bus.in_valid_i && w_in_ready;
    assign w_alloc    = w_accept && !w_rd_zero;

    rename_free_list #(
        .ARCH_REGS (ARCH_REGS),
        .PHYS_REGS (PHYS_REGS)
    ) u_free_list (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.commit_valid_i),
        .push_preg_i (bus.commit_preg_i),
        .pop_i       (w_alloc),
        .head_o      (w_fl_head),
        .count_o     (w_fl_count),
        .overflow_o  (w_fl_overflow)
    );

    // Sources and old destination are read before this instruction's own update.
    always_comb begin
        rat_d       = rat_q;
        out_valid_d = out_valid_q;
        opcode_d    = opcode_q;
        instr_d     = instr_q;
        ps1_d       = ps1_q;
        ps2_d       = ps2_q;
        pd_d        = pd_q;
        old_pd_d    = old_pd_q;
        if (w_accept) begin
            out_valid_d = 1'b1;
            opcode_d    = bus.opcode_i;
            instr_d     = bus.instr_i;
            ps1_d       = rat_q[bus.rs1_i];
            ps2_d       = rat_q[bus.rs2_i];
            pd_d        = w_rd_zero ? '0 : w_fl_head;
            old_pd_d    = w_rd_zero ? '0 : rat_q[bus.rd_i];
            if (!w_rd_zero) begin
                rat_d[bus.rd_i] = w_fl_head;
            end
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Alias table and output stage; reset restores the identity mapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rat_q[i] <= PHYS_W'(i);
            end
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            instr_q     <= '0;
            ps1_q       <= '0;
            ps2_q       <= '0;
            pd_q        <= '0;
            old_pd_q    <= '0;
        end else begin
            rat_q       <= rat_d;
            out_valid_q <= out_valid_d;
            opcode_q    <= opcode_d;
            instr_q     <= instr_d;
            ps1_q       <= ps1_d;
            ps2_q       <= ps2_d;
            pd_q        <= pd_d;
            old_pd_q    <= old_pd_d;
        end
    end

    assign bus.in_ready_o     = w_in_ready;
    assign bus.out_valid_o    = out_valid_q;
    assign bus.opcode_o       = opcode_q;
    assign bus.instr_o        = instr_q;
    assign bus.ps1_o          = ps1_q;
    assign bus.ps2_o          = ps2_q;
    assign bus.pd_o           = pd_q;
    assign bus.old_pd_o       = old_pd_q;
    assign bus.free_count_o   = w_fl_count;
    assign bus.overflow_err_o = w_fl_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rename_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_table
// Description : Directed self-checking bench for rename_table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_table;
    import rename_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    rename_table_if #(.ARCH_REGS(DEF_ARCH_REGS), .PHYS_REGS(DEF_PHYS_REGS)) bus ();

    rename_table #(
        .ARCH_REGS (DEF_ARCH_REGS),
        .PHYS_REGS (DEF_PHYS_REGS)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int rd, input int rs1, input int rs2);
        bus.in_valid_i = v;
        bus.rd_i       = areg_t'(rd);
        bus.rs1_i      = areg_t'(rs1);
        bus.rs2_i      = areg_t'(rs2);
    endtask

    task automatic commit(input logic v, input int preg);
        bus.commit_valid_i = v;
        bus.commit_preg_i  = preg_t'(preg);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        drive(1'b0, 0, 0, 0);
        commit(1'b0, 0);
        bus.opcode_i    = '0;
        bus.instr_i     = '0;
        bus.out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // reset state
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_free_count", bus.free_count_o, 32);
        chk("rst_overflow", bus.overflow_err_o, 0);
        chk("rst_pd", bus.pd_o, 0);
        chk("rst_in_ready", bus.in_ready_o, 1);

        // first rename: rd=5 rs1=5 rs2=3
        bus.opcode_i = 7'h33;
        bus.instr_i  = 32'hDEADBEEF;
        drive(1'b1, 5, 5, 3);
        step();
        drive(1'b1, 7, 1, 2);
        bus.opcode_i = 7'h13;
        bus.instr_i  = 32'h12345678;
        chk("r1_ps1", bus.ps1_o, 5);
        chk("r1_ps2", bus.ps2_o, 3);
        chk("r1_pd", bus.pd_o, 32);
        chk("r1_old_pd", bus.old_pd_o, 5);
        chk("r1_free_count", bus.free_count_o, 31);
        chk("r1_out_valid", bus.out_valid_o, 1);
        chk("r1_opcode", bus.opcode_o, 7'h33);
        chk("r1_instr", bus.instr_o, 32'hDEADBEEF);

        // back-to-back: rd=7, then rs1=7 sees the new mapping
        step();
        chk("r2_pd", bus.pd_o, 33);
        chk("r2_old_pd", bus.old_pd_o, 7);
        chk("r2_instr", bus.instr_o, 32'h12345678);
        drive(1'b1, 8, 7, 5);
        step();
        chk("r3_ps1", bus.ps1_o, 33);
        chk("r3_ps2", bus.ps2_o, 32);
        chk("r3_pd", bus.pd_o, 34);
        chk("r3_free_count", bus.free_count_o, 29);
        drive(1'b0, 0, 0, 0);
        step();
        chk("drain_out_valid", bus.out_valid_o, 0);

        // exhaust the free list with 29 more allocations to rd=9
        for (int i = 0; i < 29; i++) begin
            drive(1'b1, 9, 0, 0);
            step();
        end
        chk("exh_pd", bus.pd_o, 63);
        chk("exh_old_pd", bus.old_pd_o, 62);
        chk("exh_free_count", bus.free_count_o, 0);
        #1;
        chk("exh_in_ready_rd9", bus.in_ready_o, 0);
        drive(1'b1, 0, 9, 0);
        #1;
        chk("exh_in_ready_rd0", bus.in_ready_o, 1);
        step();
        chk("rd0_pd", bus.pd_o, 0);
        chk("rd0_old_pd", bus.old_pd_o, 0);
        chk("rd0_ps1", bus.ps1_o, 63);
        chk("rd0_free_count", bus.free_count_o, 0);

        // empty list + commit 9: no bypass, then allocation gets 9
        drive(1'b1, 4, 0, 0);
        commit(1'b1, 9);
        #1;
        chk("nobypass_in_ready", bus.in_ready_o, 0);
        step();
        commit(1'b0, 0);
        chk("cm_free_count", bus.free_count_o, 1);
        chk("cm_out_valid", bus.out_valid_o, 0);
        chk("cm_in_ready", bus.in_ready_o, 1);
        step();
        drive(1'b0, 0, 0, 0);
        chk("cm_pd", bus.pd_o, 9);
        chk("cm_old_pd", bus.old_pd_o, 4);
        chk("cm_free_count0", bus.free_count_o, 0);

        // return 40, 41, 42
        for (int i = 0; i < 3; i++) begin
            commit(1'b1, 40 + i);
            step();
        end
        commit(1'b0, 0);
        chk("ret_free_count", bus.free_count_o, 3);

        // backpressure: outputs held, no pop, then single transfer
        bus.out_ready_i = 1'b0;
        drive(1'b1, 6, 4, 0);
        step();
        drive(1'b1, 11, 0, 0);
        chk("bp_pd", bus.pd_o, 40);
        chk("bp_old_pd", bus.old_pd_o, 6);
        chk("bp_ps1", bus.ps1_o, 9);
        chk("bp_free_count", bus.free_count_o, 2);
        #1;
        chk("bp_in_ready", bus.in_ready_o, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_pd", bus.pd_o, 40);
            chk("bp_hold_valid", bus.out_valid_o, 1);
            chk("bp_hold_count", bus.free_count_o, 2);
        end
        bus.out_ready_i = 1'b1;
        drive(1'b0, 0, 0, 0);
        step();
        chk("bp_release_valid", bus.out_valid_o, 0);
        chk("bp_release_count", bus.free_count_o, 2);

        // mid-stream asynchronous reset
        bus.out_ready_i = 1'b0;
        drive(1'b1, 6, 0, 0);
        step();
        drive(1'b0, 0, 0, 0);
        chk("pre_rst_pd", bus.pd_o, 41);
        chk("pre_rst_old_pd", bus.old_pd_o, 40);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", bus.out_valid_o, 0);
        chk("mid_rst_free_count", bus.free_count_o, 32);
        chk("mid_rst_pd", bus.pd_o, 0);
        step();
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        drive(1'b1, 0, 6, 9);
        step();
        drive(1'b0, 0, 0, 0);
        chk("id_ps1", bus.ps1_o, 6);
        chk("id_ps2", bus.ps2_o, 9);
        chk("id_free_count", bus.free_count_o, 32);

        // overflow: commit to a full list with no pop
        commit(1'b1, 50);
        step();
        commit(1'b0, 0);
        chk("ovf_err", bus.overflow_err_o, 1);
        chk("ovf_free_count", bus.free_count_o, 32);

        // commit of register 0 is ignored
        drive(1'b1, 3, 0, 0);
        commit(1'b1, 0);
        step();
        chk("z_free_count", bus.free_count_o, 31);
        chk("z_pd", bus.pd_o, 32);
        chk("z_old_pd", bus.old_pd_o, 3);

        // simultaneous push and pop keeps count
        drive(1'b1, 2, 0, 0);
        commit(1'b1, 60);
        step();
        drive(1'b0, 0, 0, 0);
        commit(1'b0, 0);
        chk("pp_free_count", bus.free_count_o, 31);
        chk("pp_pd", bus.pd_o, 33);
        chk("pp_old_pd", bus.old_pd_o, 2);
        chk("pp_sticky_ovf", bus.overflow_err_o, 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rename_table.md
RENAME_TABLE -- requirements
Module: rename_table

Interface
REQ-001 Parameter ARCH_REGS, default 32, number of architectural registers.
REQ-002 Parameter PHYS_REGS, default 64, number of physical registers (> ARCH_REGS).
REQ-003 Derived constants: AW = clog2(ARCH_REGS), PW = clog2(PHYS_REGS), FL_DEPTH = PHYS_REGS-ARCH_REGS.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  decoded instruction present.
REQ-007 in_ready  out  1  instruction accepted this cycle when in_valid=1.
REQ-008 opcode  in  7  opcode; rs1, rs2, rd  in  AW each; instr  in  32  raw word.
REQ-009 out_valid  out  1  renamed instruction present; out_ready  in  1  consumer accepts.
REQ-010 opcode_  out  7; instr_  out  32  passed through unchanged.
REQ-011 ps1, ps2, pd, old_pd  out  PW each  source maps, new dest, previous dest map.
REQ-012 commit_valid  in  1; commit_preg  in  PW  physical register returned to free pool.
REQ-013 free_count  out  PW+1  entries in free list; overflow_err  out  1  sticky.

Function
REQ-014 Transfer on input when in_valid & in_ready; on output when out_valid & out_ready.
REQ-015 in_ready = (!out_valid | out_ready) & (free_count != 0 | rd == 0); combinational, no dependency on in_valid.
REQ-016 Latency exactly one cycle: an accepted instruction appears at outputs next cycle; outputs held stable while out_valid & !out_ready.
REQ-017 ps1/ps2 = RAT[rs1]/RAT[rs2] read before this instruction's own RAT update (rs1 == rd yields old mapping).
REQ-018 old_pd = RAT[rd] before update; consumer returns old_pd via commit at retirement.
REQ-019 rd != 0: pd = free-list head; head popped; RAT[rd] <= pd in the accept cycle.
REQ-020 rd == 0: pd = 0, old_pd = 0, no pop, no RAT write; accepted even when free list empty.
REQ-021 Back-to-back accepted instructions see all prior RAT writes (no stale read).
REQ-022 Free list is a circular FIFO of FL_DEPTH entries; head/tail pointers wrap modulo FL_DEPTH.
REQ-023 commit_valid pushes commit_preg at tail; commit_preg == 0 ignored.
REQ-024 Commit push and allocate pop in same cycle: both occur, free_count unchanged.
REQ-025 Empty free list: no bypass from a same-cycle commit; allocation stalls at least one cycle.
REQ-026 Push when free_count == FL_DEPTH with no simultaneous pop: discarded, overflow_err set until reset.
REQ-027 out_valid clears on output transfer with no new input transfer in the same cycle.

Reset
REQ-028 On rst: RAT[i] = i for all i; free list holds ARCH_REGS..PHYS_REGS-1 in ascending order, head at ARCH_REGS.
REQ-029 On rst: free_count = FL_DEPTH, out_valid = 0, overflow_err = 0, all data outputs 0.
REQ-030 rst asserted mid-stream discards the held output and any in-flight allocation; no partial RAT update survives.

Structure
REQ-031 Package rename_pkg holds ARCH_REGS, PHYS_REGS defaults, AW/PW, and typedefs areg_t, preg_t.
REQ-032 Free list is sub-module rename_free_list (push/pop/count/overflow); RAT and output register in rename_table.

Verification
REQ-033 After reset, rd=5, rs1=5, rs2=3 -> next cycle ps1=5, ps2=3, pd=32, old_pd=5, free_count=31.
REQ-034 Two instructions rd=7 then rs1=7 back-to-back -> second ps1=32 (first pd).
REQ-035 32 allocations with no commits -> free_count=0, in_ready=0 for rd!=0, in_ready=1 for rd=0 with pd=0.
REQ-036 Empty list plus commit_preg=9 -> free_count=1 next cycle, next allocation pd=9.
REQ-037 out_ready=0 for 3 cycles -> outputs unchanged, in_ready=0, no pop; release -> single transfer.
REQ-038 Commit at full list -> overflow_err=1, free_count stays 32; rst mid-stream -> RAT identity, out_valid=0.
